// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, MSB first, one start bit and one stop bit.
// A byte is accepted when tx_valid and tx_ready are both high on a rising edge.
// The serial line and the done pulse are registered so that they are glitch-free.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_done
);

  // Final count value of one bit period; the counter wraps to zero after it.
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        bit_end_s;

  assign bit_end_s = (cnt_q == BIT_LAST);

  // Ready is combinational on rst so the block refuses bytes while reset is held.
  assign tx_ready  = (state_q == ST_IDLE) && !rst;
  assign tx        = tx_q;
  assign tx_done   = done_q;

  // Next-state logic; tx and done are computed from the next state so the
  // registered outputs line up with the cycle the state is in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
          tx_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          tx_d    = shift_q[7];
        end else begin
          cnt_d = cnt_q + 16'd1;
          tx_d  = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d = 16'd0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            tx_d    = shift_q[6];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end_s) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
    // Done marks the final cycle of the stop bit.
    done_d = (state_d == ST_STOP) && (cnt_d == BIT_LAST);
  end

  // State and output registers with synchronous reset that aborts any frame.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a 434-clock instance for the long-frame scenarios and a
// 2-clock instance for table vectors and randomized traffic. Both are tracked
// every cycle by a frame-position reference model.
module tb_uart_tx;

  logic clk;
  logic rst_a, valid_a, ready_a, tx_a, done_a;
  logic rst_b, valid_b, ready_b, tx_b, done_b;
  logic [7:0] data_a, data_b;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(434)) dut_a (
    .clk_50M(clk), .rst(rst_a), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(2)) dut_b (
    .clk_50M(clk), .rst(rst_b), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per instance: busy flag, cycle index inside the frame, and the latched byte.
  bit         m_known [2];
  bit         m_busy  [2];
  int         m_c     [2];
  logic [7:0] m_byte  [2];

  // Line level for frame slot k: 0 = start, 1..8 = data MSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {1'b0, b, 1'b1};
    return f[9 - k];
  endfunction

  task automatic model_step(input int i, input logic r, input logic v,
                            input logic [7:0] d, input int p);
    if (r) begin
      m_known[i] = 1'b1;
      m_busy[i]  = 1'b0;
      m_c[i]     = 0;
    end else if (m_known[i]) begin
      if (m_busy[i]) begin
        m_c[i] = m_c[i] + 1;
        if (m_c[i] == 10 * p) m_busy[i] = 1'b0;
      end else if (v) begin
        m_busy[i] = 1'b1;
        m_c[i]    = 0;
        m_byte[i] = d;
      end
    end
  endtask

  task automatic model_check(input int i, input logic r, input logic t,
                             input logic dn, input logic rd, input int p);
    logic et, ed, er;
    if (m_known[i]) begin
      et = m_busy[i] ? frame_bit(m_byte[i], m_c[i] / p) : 1'b1;
      ed = m_busy[i] && (m_c[i] == 10 * p - 1);
      er = !m_busy[i] && !r;
      checks++;
      if ({t, dn, rd} !== {et, ed, er}) begin
        errors++;
        $display("FAIL model_dut%0d at t=%0t: tx/done/ready got %b%b%b expected %b%b%b",
                 i, $time, t, dn, rd, et, ed, er);
      end
    end
  endtask

  // Model advances on the same edge as the DUTs, using inputs stable at that edge.
  always @(posedge clk) begin
    model_step(0, rst_a, valid_a, data_a, 434);
    model_step(1, rst_b, valid_b, data_b, 2);
  end

  // Outputs compared against the model in the middle of every cycle.
  always @(negedge clk) begin
    model_check(0, rst_a, tx_a, done_a, ready_a, 434);
    model_check(1, rst_b, tx_b, done_b, ready_b, 2);
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (ready_a !== 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
    check("idle_timeout_a", 32'(ready_a), 32'd1);
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first_hi, done_idx, done_cnt, hi_cnt, nready, r0, r1, r2;
    logic ready_after;
    logic [9:0] cap, ev, od;

    vecs[0] = '{data: 8'h80, frame: 10'b0_10000000_1};
    vecs[1] = '{data: 8'hA5, frame: 10'b0_10100101_1};
    vecs[2] = '{data: 8'h3C, frame: 10'b0_00111100_1};
    vecs[3] = '{data: 8'hFF, frame: 10'b0_11111111_1};
    vecs[4] = '{data: 8'h00, frame: 10'b0_00000000_1};
    vecs[5] = '{data: 8'h01, frame: 10'b0_00000001_1};

    rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
    rst_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
    tick(3);

    // Reset state, and tx_valid ignored while reset is high.
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd0);
    valid_a = 1'b1; data_a = 8'hFF;
    tick(1);
    check("rst_valid_tx", 32'(tx_a), 32'd1);
    check("rst_valid_ready", 32'(ready_a), 32'd0);

    // Release reset with a byte already offered: accepted on the first edge.
    rst_a = 1'b0; rst_b = 1'b0; data_a = 8'h01;
    #1;
    check("ready_after_release", 32'(ready_a), 32'd1);
    @(posedge clk);
    #1;
    valid_a = 1'b0; data_a = 8'h00;
    first_hi = -1; done_idx = -1; done_cnt = 0; hi_cnt = 0; ready_after = 1'b0;
    for (int c = 0; c < 4341; c++) begin
      @(negedge clk);
      if (tx_a === 1'b1 && first_hi < 0) first_hi = c;
      if (c >= 3472 && c < 4340 && tx_a === 1'b1) hi_cnt++;
      if (done_a === 1'b1) begin done_cnt++; done_idx = c; end
      if (c == 4340) ready_after = ready_a;
    end
    check("byte01_low_run", 32'(first_hi), 32'd3472);
    check("byte01_high_tail", 32'(hi_cnt), 32'd868);
    check("byte01_done_cnt", 32'(done_cnt), 32'd1);
    check("byte01_done_idx", 32'(done_idx), 32'd4339);
    check("byte01_ready_after", 32'(ready_after), 32'd1);
    tick(1);

    // Back-to-back with tx_valid held: ready high one cycle per 4341.
    valid_a = 1'b1; data_a = 8'h55;
    nready = 0; r0 = -1; r1 = -1; r2 = -1;
    for (int c = 0; c < 8690; c++) begin
      @(negedge clk);
      if (ready_a === 1'b1) begin
        if (nready == 0) r0 = c;
        else if (nready == 1) r1 = c;
        else if (nready == 2) r2 = c;
        nready++;
      end
    end
    check("b2b_ready_count", 32'(nready), 32'd3);
    check("b2b_period1", 32'(r1 - r0), 32'd4341);
    check("b2b_period2", 32'(r2 - r1), 32'd4341);
    tick(1);
    valid_a = 1'b0;
    wait_idle_a();

    // tx_data and tx_valid wiggle mid-frame; the line must still carry 0xF0.
    valid_a = 1'b1; data_a = 8'hF0;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    cap = 10'd0;
    for (int c = 0; c < 4340; c++) begin
      @(negedge clk);
      if (c % 434 == 217) cap = {cap[8:0], tx_a};
      @(posedge clk);
      #1;
      if (c == 999)  data_a = 8'h0F;
      if (c == 1499) valid_a = 1'b1;
      if (c == 2999) valid_a = 1'b0;
    end
    check("f0_frame", 32'(cap), 32'({1'b0, 8'hF0, 1'b1}));

    // Reset at cycle 2000 of a 0x00 frame aborts it with no done pulse.
    valid_a = 1'b1; data_a = 8'h00;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt++;
      @(posedge clk);
      #1;
      if (c == 1999) rst_a = 1'b1;
    end
    @(posedge clk);
    #1;
    check("abort_tx", 32'(tx_a), 32'd1);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_ready", 32'(ready_a), 32'd0);
    rst_a = 1'b0;
    #1;
    check("abort_ready_release", 32'(ready_a), 32'd1);
    for (int c = 0; c < 4400; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    tick(1);

    // Table vectors on the 2-clock instance: each bit 2 cycles, done at 19.
    for (int i = 0; i < 6; i++) begin
      valid_b = 1'b1; data_b = vecs[i].data;
      @(posedge clk);
      #1;
      valid_b = 1'b0; data_b = ~vecs[i].data;
      ev = 10'd0; od = 10'd0; done_idx = -1; done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c % 2 == 0) ev = {ev[8:0], tx_b};
        else            od = {od[8:0], tx_b};
        if (done_b === 1'b1) begin done_cnt++; done_idx = c; end
      end
      @(posedge clk);
      #1;
      check("vec_frame_first_half", 32'(ev), 32'(vecs[i].frame));
      check("vec_frame_second_half", 32'(od), 32'(vecs[i].frame));
      check("vec_done_idx", 32'(done_idx), 32'd19);
      check("vec_done_cnt", 32'(done_cnt), 32'd1);
      check("vec_ready_after", 32'(ready_b), 32'd1);
    end

    // Randomized traffic with occasional resets, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      rst_b   = ($urandom_range(0, 63) == 0);
      valid_b = ($urandom_range(0, 2) != 0);
      data_b  = 8'($urandom);
      tick(1);
    end
    rst_b = 1'b0; valid_b = 1'b0;
    tick(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide parameter CLKS_PER_BIT, default 434, meaning clk_50M cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL provide port clk_50M  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk_50M.
REQ-004 The block SHALL provide port tx_valid  input  1  a byte on tx_data is offered for transmission.
REQ-005 The block SHALL provide port tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-006 The block SHALL provide port tx_ready  output  1  high when the block can accept a byte this cycle.
REQ-007 The block SHALL provide port tx  output  1  serial line to the downstream uart_rx; idle high.
REQ-008 The block SHALL provide port tx_done  output  1  one-cycle pulse marking the last cycle of a frame's stop bit.

Function
REQ-009 The block SHALL implement the states IDLE, START, DATA and STOP, using a bit-period counter of at least 16 bits and a 3-bit data-bit index.
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), then 8 data bits MSB first (tx_data[7] first), then 1 stop bit (1); 10*CLKS_PER_BIT cycles per frame. MSB-first order matches the existing uart_rx.
REQ-011 tx_ready SHALL be 1 exactly when the state is IDLE and rst is low.
REQ-012 Acceptance SHALL occur at a rising edge E0 where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a shift register at E0.
REQ-013 Changes to tx_data or tx_valid after E0 SHALL NOT affect the frame in progress; tx_valid is ignored outside IDLE.
REQ-014 tx SHALL be 0 in the cycles E0+0 .. E0+CLKS_PER_BIT-1 (cycles counted after E0).
REQ-015 Data bit k (k=0 for tx_data[7]) SHALL drive tx during cycles E0+CLKS_PER_BIT*(1+k) .. E0+CLKS_PER_BIT*(2+k)-1.
REQ-016 tx SHALL be 1 during stop cycles E0+9*CLKS_PER_BIT .. E0+10*CLKS_PER_BIT-1.
REQ-017 tx_done SHALL be 1 only during cycle E0+10*CLKS_PER_BIT-1; it SHALL be 0 at all other times.
REQ-018 At edge E0+10*CLKS_PER_BIT the state SHALL return to IDLE, so tx_ready=1 in the following cycle.
REQ-019 Back-to-back transfers with tx_valid held high SHALL have exactly one idle-high cycle between the stop bit and the next start bit; the frame period is 10*CLKS_PER_BIT+1 cycles.
REQ-020 In IDLE, tx SHALL be 1 and tx_done SHALL be 0.
REQ-021 tx SHALL be driven from a register so that it is glitch-free.
REQ-022 The bit counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary, with no drift across the frame.

Reset
REQ-023 While rst=1 at a rising edge, the following SHALL hold in the next cycle, regardless of the current state: state=IDLE, tx=1, tx_ready=0 (forced low while rst is high), tx_done=0, counters=0 and shift register=0x00.
REQ-024 If rst is asserted mid-frame, the frame SHALL be aborted and tx SHALL return high in the next cycle.
REQ-025 If rst and tx_valid are high together, tx_valid SHALL be ignored.
REQ-026 After rst is released, tx_ready SHALL be 1 in the first cycle, and a byte SHALL be accepted on that edge.

Verification
REQ-027 Scenario: reset, then tx_valid=1 with tx_data=0x01 for one cycle -> tx=0 for 434 cycles, then 0 for seven bit periods, then 1 (bit 0), then 1 (stop); tx_done pulses at cycle 4339.
REQ-028 Scenario: loopback of tx into uart_rx, sending 0xA5, 0x3C and 0xFF -> rx_msg equals each byte and rx_complete pulses once per frame.
REQ-029 Scenario: tx_valid held high with tx_data=0x55 -> tx_ready=0 for 4340 cycles, then 1 for exactly one cycle, then the next start bit begins; period 4341 cycles.
REQ-030 Scenario: send 0xF0 and change tx_data to 0x0F at cycle 1000 of the frame -> the line still carries 0xF0.
REQ-031 Scenario: assert rst at cycle 2000 of a 0x00 frame -> tx=1 and tx_done=0 in the next cycle, with no tx_done pulse for that frame.
REQ-032 Scenario: CLKS_PER_BIT=2, send 0x80 -> frame lasts 20 cycles, tx_done is high in cycle 19 only, and each bit lasts exactly 2 cycles.
